// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Instruction fetch stage. It owns the PC and drives imem read
//            port 0, which returns data one clock after the address.
//            Fetched words are buffered in a FIFO and handed to decode.
//            Optional performance counters: define IFU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h80000000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic                  inst_misalign
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [63:0]           perf_fetch_cnt,
   output logic [63:0]           perf_stall_cnt
`endif
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W:0]    c_DEPTH = (c_CNT_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);

   // Fetch / in-flight state
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic                  r_inflight_valid;
   logic [ADDR_WIDTH-1:0] r_inflight_pc;
   logic                  r_inflight_misalign;

   // Instruction buffer
   logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic                  r_fifo_mis  [FIFO_DEPTH];
   logic [c_CNT_W-1:0]    r_count;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_PTR_W-1:0]    r_wr_ptr;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic [c_CNT_W:0]      w_occupancy;
   logic [ADDR_WIDTH-1:0] w_target;
   logic                  w_target_mis;

   assign w_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign w_target_mis = |redirect_pc[1:0];

   assign inst_valid = (r_count != '0);
   assign w_pop      = inst_valid && inst_ready;
   assign w_push     = r_inflight_valid && !redirect_valid;

   // Slots already promised to words in the buffer or on the memory bus.
   // A pop implies r_count >= 1, so this never underflows.
   assign w_occupancy = {1'b0, r_count}
                      + (c_CNT_W+1)'(r_inflight_valid)
                      - (c_CNT_W+1)'(w_pop);
   assign w_issue     = (w_occupancy < c_DEPTH) && !redirect_valid;

   assign imem_addr = redirect_valid ? w_target : r_fetch_pc;

   // Head is exposed only while valid so that idle outputs read as zero.
   assign inst_pc       = inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;
   assign inst_data     = inst_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign inst_misalign = inst_valid ? r_fifo_mis[r_rd_ptr]  : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc          <= RESET_PC;
         r_inflight_valid    <= 1'b0;
         r_inflight_pc       <= '0;
         r_inflight_misalign <= 1'b0;
      end else if (redirect_valid) begin
         r_fetch_pc          <= w_target + c_PC_STEP;
         r_inflight_valid    <= 1'b1;
         r_inflight_pc       <= w_target;
         r_inflight_misalign <= w_target_mis;
      end else if (w_issue) begin
         r_fetch_pc          <= r_fetch_pc + c_PC_STEP;
         r_inflight_valid    <= 1'b1;
         r_inflight_pc       <= r_fetch_pc;
         r_inflight_misalign <= 1'b0;
      end else begin
         r_inflight_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (redirect_valid) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: it is never visible while the buffer is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
         r_fifo_data[r_wr_ptr] <= imem_data;
         r_fifo_mis[r_wr_ptr]  <= r_inflight_misalign;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [63:0] r_perf_fetch_cnt;
   logic [63:0] r_perf_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch_cnt <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 64'd1;
         end
         if (inst_valid && !inst_ready) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 64'd1;
         end
      end
   end

   assign perf_fetch_cnt = r_perf_fetch_cnt;
   assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the unified memory model. Owns the PC and drives the memory's instruction read port 0. That port returns data registered one clock after the address is sampled. Fetched instructions are buffered in a small FIFO and handed to decode over a valid/ready handshake. Branch/jump redirects from execute flush the stage.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h80000000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk  input  1  single clock, all state on posedge
rst_n  input  1  asynchronous, active-low reset
imem_addr  output  ADDR_WIDTH  to memory read port 0 address; sampled by memory on posedge
imem_data  input  DATA_WIDTH  memory read port 0 data; valid the cycle after address sampled
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  ADDR_WIDTH  redirect target
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode accepts head
inst_pc  output  ADDR_WIDTH  PC of head
inst_data  output  DATA_WIDTH  instruction word of head
inst_misalign  output  1  head came from target with pc[1:0] != 0

Behaviour:
- State: fetch_pc, inflight_valid, inflight_pc, inflight_misalign, FIFO (entries {pc, data, misalign}), count, rd/wr pointers.
- Reset (async, rst_n=0): fetch_pc=RESET_PC, inflight_valid=0, FIFO empty. Outputs: inst_valid=0, inst_pc=0, inst_data=0, inst_misalign=0, imem_addr=RESET_PC.
- pop = inst_valid && inst_ready. inst_* are driven from FIFO head only; no bypass.
- Issue condition: (count + inflight_valid - pop) < FIFO_DEPTH, and no redirect this cycle.
- imem_addr is combinational: {redirect_pc[ADDR_WIDTH-1:2],2'b00} if redirect_valid, else fetch_pc.
- The memory reads every cycle. Data is consumed only when inflight_valid=1.
- On issue, at posedge: inflight_valid=1, inflight_pc=fetch_pc, fetch_pc=fetch_pc+4 (mod 2^ADDR_WIDTH, wraps to 0).
- If not issuing: inflight_valid=0 and fetch_pc holds.
- Push: when inflight_valid=1 and no redirect, {inflight_pc, imem_data, inflight_misalign} is written at the tail at posedge.
- Push and pop in the same cycle are legal at any occupancy, including full. The issue rule guarantees no overflow.
- Redirect (priority over everything):
  - At posedge, FIFO is flushed (count=0) and the current pop and push are discarded.
  - The redirect address is issued: inflight_valid=1, inflight_pc=aligned target, inflight_misalign=|redirect_pc[1:0].
  - fetch_pc = aligned target + 4.
  - Redirect in cycle N -> inst_valid=0 in N+1 -> target instruction on inst_* in N+2.
- Misaligned target: fetch proceeds from the aligned address; only that first entry carries misalign=1. Sequential successors carry 0.
- Steady state with inst_ready=1: one instruction per cycle. First inst_valid is 2 cycles after reset release.
- inst_ready low: FIFO fills to FIFO_DEPTH, then issue stops. No instruction is dropped or duplicated, and order is preserved.
- Reset asserted mid-operation: all state clears immediately. Fetch restarts from RESET_PC after release.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt (64) and perf_stall_cnt (64), both reset to 0.
  - perf_fetch_cnt increments on each pop.
  - perf_stall_cnt increments each cycle inst_valid=1 && inst_ready=0.
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Release reset, inst_ready=1, memory returns addr^32'h5A5A5A5A -> imem_addr=0x80000000 in cycle 0; inst_valid=1 in cycle 2 with pc 0x80000000; then pc 0x80000004, 0x80000008, ... one per cycle.
- inst_ready=0 for 6 cycles after first valid -> count saturates at 2, inflight_valid drops to 0. On release, pcs 0x80000000, 0x80000004, 0x80000008 appear consecutively with correct data.
- FIFO full, redirect_valid=1, redirect_pc=0x80000100 in cycle N -> imem_addr=0x80000100 in N; inst_valid=0 in N+1; inst_pc=0x80000100 in N+2, then 0x80000104.
- redirect_pc=0x80000102 -> imem_addr=0x80000100; head pc=0x80000100 with inst_misalign=1; next entry 0x80000104 with inst_misalign=0.
- redirect_pc=0xFFFFFFFC, inst_ready=1 -> inst_pc 0xFFFFFFFC, then 0x00000000.
- rst_n pulsed low mid-stream (asynchronous, between edges) -> inst_valid=0 immediately. After release, first pc is 0x80000000 at cycle 2. With IFU_PERF_CNT_EN, both counters read 0.
